// File: rtl/debounce_pkg.sv
// Shared types and helpers for the input debouncer.
// State encoding for the stability FSM plus the counter width calculation.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } db_state_e;

    function automatic int cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer with a parameterized reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw level input into a clean synchronous level.
// Define INPUT_DEBOUNCER_SYNC_EN to insert a two-flop synchronizer ahead of the FSM.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic d_o,
    output logic busy_o,
    output logic glitch_o
);

    localparam int             CW        = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam db_state_e      RST_STATE = RST_VAL ? STABLE_HI : STABLE_LO;

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_param
            $error("input_debouncer: STABLE_CYCLES must be >= 2");
        end
    endgenerate

    logic s;

`ifdef INPUT_DEBOUNCER_SYNC_EN
    sync_2ff #(.RST_VAL(RST_VAL)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (d_i),
        .q_o (s)
    );
`else
    assign s = d_i;
`endif

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          d_o_q, d_o_d;
    logic          busy_q, busy_d;
    logic          glitch_q, glitch_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RST_STATE;
            cnt_q    <= '0;
            d_o_q    <= RST_VAL;
            busy_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_o_q    <= d_o_d;
            busy_q   <= busy_d;
            glitch_q <= glitch_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_o_d    = d_o_q;
        glitch_d = 1'b0;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d  = STABLE_LO;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    d_o_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d  = STABLE_HI;
                    cnt_d    = '0;
                    glitch_d = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    d_o_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            // Unreachable encodings fall back to the stable state matching the output.
            default: begin
                state_d = d_o_q ? STABLE_HI : STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    assign d_o      = d_o_q;
    assign busy_o   = busy_q;
    assign glitch_o = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: stimulus queues expected output-change events,
// a negedge monitor pops and compares them as the outputs move.
module tb_input_debouncer;

    localparam int SC = 4;
`ifdef INPUT_DEBOUNCER_SYNC_EN
    localparam int O = 2;
`else
    localparam int O = 0;
`endif

    typedef struct {
        int kind;   // 0 d_o, 1 busy_o, 2 glitch_o
        bit val;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    logic d_i, d_i1;
    logic d_o, busy_o, glitch_o;
    logic d_o1, busy_o1, glitch_o1;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic prev[3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    input_debouncer #(.STABLE_CYCLES(SC), .RST_VAL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .d_i(d_i),
        .d_o(d_o), .busy_o(busy_o), .glitch_o(glitch_o)
    );

    input_debouncer #(.STABLE_CYCLES(SC), .RST_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .d_i(d_i1),
        .d_o(d_o1), .busy_o(busy_o1), .glitch_o(glitch_o1)
    );

    // Monitor: every output change of dut0 must match the next queued event.
    always @(negedge clk) begin
        if (mon_en) begin
            logic cur[3];
            cur[0] = d_o; cur[1] = busy_o; cur[2] = glitch_o;
            for (int k = 0; k < 3; k++) begin
                if (cur[k] !== prev[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event kind=%0d val=%b cyc=%0d (none expected)", k, cur[k], cyc);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if (e.kind != k || e.val !== cur[k] || e.cyc != cyc) begin
                            errors++;
                            $display("FAIL event got kind=%0d val=%b cyc=%0d, required kind=%0d val=%b cyc=%0d",
                                     k, cur[k], cyc, e.kind, e.val, e.cyc);
                        end
                    end
                    prev[k] = cur[k];
                end
            end
            checks++;
            if ({d_o1, busy_o1, glitch_o1} !== 3'b100) begin
                errors++;
                $display("FAIL rstval1_idle got %b required 100 at cyc %0d", {d_o1, busy_o1, glitch_o1}, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input bit val, input int c);
        ev_t e;
        e.kind = kind; e.val = val; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    // Input moves to v and stays there long enough to qualify.
    task automatic clean_edge(input bit v, input string name);
        int n;
        n = cyc + 1;
        d_i = v;
        push(1, 1'b1, n + O);
        push(0, v,    n + O + SC);
        push(1, 1'b0, n + O + SC);
        tick(O + SC + 3);
        chk(name, exp_q.size(), 0);
    endtask

    // Input moves to v for k evaluations (k <= SC) and returns: must glitch.
    task automatic bounce(input bit v, input int k, input string name);
        int n;
        n = cyc + 1;
        d_i = v;
        push(1, 1'b1, n + O);
        push(1, 1'b0, n + O + k);
        push(2, 1'b1, n + O + k);
        push(2, 1'b0, n + O + k + 1);
        tick(k);
        d_i = ~v;
        tick(O + SC + 4);
        chk(name, exp_q.size(), 0);
    endtask

    // Input moves to v for SC+1 evaluations: qualifies, then the return qualifies too.
    task automatic bounce_pass(input bit v, input string name);
        int n;
        n = cyc + 1;
        d_i = v;
        push(1, 1'b1, n + O);
        push(0, v,    n + O + SC);
        push(1, 1'b0, n + O + SC);
        push(1, 1'b1, n + O + SC + 1);
        push(0, ~v,   n + O + 2*SC + 1);
        push(1, 1'b0, n + O + 2*SC + 1);
        tick(SC + 1);
        d_i = ~v;
        tick(O + SC + 4);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic reset_mid_wait();
        int n, n2;
        n = cyc + 1;
        d_i = 1'b1;
        push(1, 1'b1, n + O);
        push(1, 1'b0, n + O + 2);
        tick(O + 2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_d_o", int'(d_o), 0);
        chk("rst_mid_busy", int'(busy_o), 0);
        chk("rst_mid_glitch", int'(glitch_o), 0);
        n2 = n + O + 3;
        push(1, 1'b1, n2 + O);
        push(0, 1'b1, n2 + O + SC);
        push(1, 1'b0, n2 + O + SC);
        tick(2*O + SC + 4);
        chk("rst_mid_requalify", exp_q.size(), 0);
    endtask

    initial begin
        rst  = 1'b1;
        d_i  = 1'b0;
        d_i1 = 1'b1;
        tick(3);
        rst = 1'b0;
        chk("reset_d_o", int'(d_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_glitch", int'(glitch_o), 0);
        chk("reset_d_o_rstval1", int'(d_o1), 1);
        prev[0] = 1'b0; prev[1] = 1'b0; prev[2] = 1'b0;
        mon_en = 1'b1;
        tick(20);

        clean_edge(1'b1, "clean_rise");
        clean_edge(1'b0, "clean_fall");
        bounce(1'b1, 3, "bounce_hi_3");
        bounce(1'b1, 4, "bounce_hi_exact");
        bounce(1'b1, 1, "bounce_hi_1");
        bounce_pass(1'b1, "pass_hi_5");
        clean_edge(1'b1, "clean_rise_2");
        bounce(1'b0, 3, "bounce_lo_3");
        bounce(1'b0, 4, "bounce_lo_exact");
        bounce_pass(1'b0, "pass_lo_5");
        clean_edge(1'b0, "clean_fall_2");
        reset_mid_wait();
        clean_edge(1'b0, "fall_after_rst");

        tick(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
